add_acc_pipe: RTL

Parametrised, pipelined successor to the fixed 8-bit ADD→REG datapath. It truncates two operands of independent widths to DATAWIDTH, adds them, and accumulates the result into one of NCH per-channel accumulators. Each result is presented on a registered output with a valid/ready handshake. It sits between upstream datapath producers and REG/COMP consumers in generated netlists that need running sums rather than a single registered sum.

---
 rtl/add_acc_pkg.sv | 51 +++++
 rtl/add_acc_bank.sv | 50 +++++
 rtl/add_acc_pipe.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/add_acc_pkg.sv
// add_acc_pkg
// Shared definitions for the add_acc_pipe accumulator datapath.
//
// Contents:
//   DEF_*        default DATAWIDTH / AWIDTH / BWIDTH / NCH values
//   MAX_DW       widest DATAWIDTH the shared arithmetic helper handles
//   MAX_CHW      widest channel index the result record can carry
//   acc_result_t result record (channel, sum, overflow flag)
//   add_acc_op   add of two DATAWIDTH-wide values with carry-out or
//                saturation, used by both pipeline stages
package add_acc_pkg;

  localparam int DEF_DATAWIDTH = 8;
  localparam int DEF_AWIDTH    = 32;
  localparam int DEF_BWIDTH    = 16;
  localparam int DEF_NCH       = 4;

  // The helper works on a fixed wide vector so that one function serves
  // every parametrisation; callers keep only the low DATAWIDTH bits.
  localparam int MAX_DW  = 64;
  localparam int MAX_CHW = 8;

  typedef struct packed {
    logic [MAX_CHW-1:0] ch;
    logic [MAX_DW-1:0]  sum;
    logic               ovf;
  } acc_result_t;

  // Adds the low dw bits of x and y. ovf reports the carry out of bit dw-1.
  // With sat set, an overflowing add returns all-ones in the low dw bits
  // instead of the wrapped value; ovf still marks that it happened.
  function automatic acc_result_t add_acc_op(input logic [MAX_DW-1:0] x,
                                             input logic [MAX_DW-1:0] y,
                                             input int unsigned       dw,
                                             input bit                sat);
    logic [MAX_DW-1:0] mask;
    logic [MAX_DW:0]   full;
    acc_result_t       r;
    mask  = ~({MAX_DW{1'b1}} << dw);
    full  = {1'b0, x & mask} + {1'b0, y & mask};
    r.ch  = '0;
    // Both operands are masked, so anything at or above bit dw is the carry.
    r.ovf = |(full >> dw);
    r.sum = full[MAX_DW-1:0] & mask;
    if (sat && r.ovf) begin
      r.sum = mask;
    end
    return r;
  endfunction

endpackage

// File: rtl/add_acc_bank.sv
// add_acc_bank
// Array of NCH accumulators, DATAWIDTH bits each, with one combinational
// read port and one synchronous write port. A synchronous active-low reset
// clears every entry.
//
// Ports:
//   clk      clock, all updates on the rising edge
//   rst      synchronous reset, active low
//   rd_ch    read channel index
//   rd_data  contents of accumulator rd_ch (zero when rd_ch >= NCH)
//   wr_en    write strobe
//   wr_ch    write channel index (ignored when >= NCH)
//   wr_data  value written into accumulator wr_ch
module add_acc_bank #(
  parameter int DATAWIDTH = 8,
  parameter int NCH       = 4,
  parameter int CHW       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CHW-1:0]       rd_ch,
  output logic [DATAWIDTH-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [CHW-1:0]       wr_ch,
  input  logic [DATAWIDTH-1:0] wr_data
);

  localparam logic [CHW:0] NCH_V = (CHW+1)'(NCH);

  logic [DATAWIDTH-1:0] mem [NCH];
  logic                 rd_ok;
  logic                 wr_ok;

  // When NCH is not a power of two some index codes have no storage behind
  // them; those read as zero and never write.
  assign rd_ok   = ({1'b0, rd_ch} < NCH_V);
  assign wr_ok   = ({1'b0, wr_ch} < NCH_V);
  assign rd_data = rd_ok ? mem[rd_ch] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && wr_ok) begin
      mem[wr_ch] <= wr_data;
    end
  end

endmodule

// File: rtl/add_acc_pipe.sv
// add_acc_pipe
// Two-stage pipelined add-and-accumulate datapath. Stage 1 truncates both
// operands to DATAWIDTH and adds them; stage 2 adds that sum onto one of NCH
// per-channel accumulators (or onto zero when in_clr was set) and presents
// the new value on a registered valid/ready output.
//
// Optional feature: define ADD_ACC_SAT_EN to make both adds saturate to
// all-ones instead of wrapping. The default build wraps modulo 2^DATAWIDTH.
//
// Ports:
//   clk        clock, all updates on the rising edge
//   rst        synchronous reset, active low
//   in_valid   input beat present
//   in_ready   beat accepted this cycle (depends only on out_valid/out_ready)
//   in_ch      target accumulator channel
//   in_clr     ignore the channel's prior sum; result is a+b only
//   a, b       operands; only the low DATAWIDTH bits take part
//   out_valid  result present
//   out_ready  consumer takes the result
//   out_ch     channel the result belongs to
//   c          new accumulator value
//   out_ovf    carry (or saturation) in either add, or channel out of range
module add_acc_pipe
  import add_acc_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int AWIDTH    = DEF_AWIDTH,
  parameter int BWIDTH    = DEF_BWIDTH,
  parameter int NCH       = DEF_NCH,
  parameter int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CHW-1:0]       in_ch,
  input  logic                 in_clr,
  input  logic [AWIDTH-1:0]    a,
  input  logic [BWIDTH-1:0]    b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CHW-1:0]       out_ch,
  output logic [DATAWIDTH-1:0] c,
  output logic                 out_ovf
);

`ifdef ADD_ACC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [CHW:0] NCH_V = (CHW+1)'(NCH);

  logic                 advance;

  logic                 s1_valid;
  logic [DATAWIDTH-1:0] s1_sum;
  logic                 s1_c1;
  logic [CHW-1:0]       s1_ch;
  logic                 s1_clr;

  acc_result_t          r1;
  acc_result_t          r2;
  logic                 ch_ok;
  logic [DATAWIDTH-1:0] rd_data;
  logic [DATAWIDTH-1:0] base;
  logic                 acc_wr;
  logic                 unused_bits;

  // Both stages move together: the whole pipe stalls only while a result is
  // waiting on the output and the consumer is not taking it.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // The wide casts truncate a wider operand and zero-extend a narrower one;
  // the helper then keeps just the low DATAWIDTH bits.
  always_comb begin
    r1 = add_acc_op(MAX_DW'(a), MAX_DW'(b), DATAWIDTH, SAT_EN);
  end

  // Stage 1 captures whatever sits on the inputs on every advance, so a
  // bubble simply travels down the pipe with s1_valid low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_c1    <= 1'b0;
      s1_ch    <= '0;
      s1_clr   <= 1'b0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_sum   <= r1.sum[DATAWIDTH-1:0];
      s1_c1    <= r1.ovf;
      s1_ch    <= in_ch;
      s1_clr   <= in_clr;
    end
  end

  // Out-of-range channels accumulate onto zero, flag overflow and leave the
  // bank alone. Reading and writing the bank only here is what lets
  // back-to-back beats to one channel see each other without forwarding.
  always_comb begin
    ch_ok  = ({1'b0, s1_ch} < NCH_V);
    base   = (s1_clr || !ch_ok) ? '0 : rd_data;
    r2     = add_acc_op(MAX_DW'(base), MAX_DW'(s1_sum), DATAWIDTH, SAT_EN);
    acc_wr = advance && s1_valid && ch_ok;
  end

  add_acc_bank #(
    .DATAWIDTH (DATAWIDTH),
    .NCH       (NCH),
    .CHW       (CHW)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .rd_ch   (s1_ch),
    .rd_data (rd_data),
    .wr_en   (acc_wr),
    .wr_ch   (s1_ch),
    .wr_data (r2.sum[DATAWIDTH-1:0])
  );

  // The output register only changes on a real beat; bubbles drop out_valid
  // but keep the last c/out_ch/out_ovf on the bus.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      c         <= '0;
      out_ch    <= '0;
      out_ovf   <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        c       <= r2.sum[DATAWIDTH-1:0];
        out_ch  <= s1_ch;
        out_ovf <= s1_c1 | r2.ovf | !ch_ok;
      end
    end
  end

  // High bits of the shared helper's wide result are always zero here.
  assign unused_bits = ^{r1.ch, r1.sum[MAX_DW-1:DATAWIDTH],
                         r2.ch, r2.sum[MAX_DW-1:DATAWIDTH]};

endmodule
